// File: rtl/reimu_bullet.sv
// Player shot engine: a small pool of upward-moving bullets, bullet/boss
// collision detection and the boss HP counter with its IDLE/FIGHT/DEAD FSM.
module reimu_bullet #(
  parameter int NB       = 4,
  parameter int SPEED    = 12,
  parameter int COOLDOWN = 3,
  parameter int BOSS_HP  = 40,
  parameter int HIT_DX   = 24,
  parameter int HIT_DY   = 28
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               gamestart,
  input  logic               boss,
  input  logic               fire,
  input  logic [9:0]         reimux,
  input  logic [9:0]         reimuy,
  input  logic [9:0]         bossx,
  input  logic [9:0]         bossy,
  output logic [NB-1:0]      bullet_v,
  output logic [10*NB-1:0]   bullet_x,
  output logic [10*NB-1:0]   bullet_y,
  output logic               boss_hit,
  output logic [6:0]         boss_hp,
  output logic               boss_dead
);

  localparam int CDW  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam int CNTW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIGHT = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   v_q, v_d;
  logic [9:0]      x_q [NB];
  logic [9:0]      x_d [NB];
  logic [9:0]      y_q [NB];
  logic [9:0]      y_d [NB];
  logic [CDW-1:0]  cd_q, cd_d;
  logic [6:0]      hp_q, hp_d;
  logic            hit_q, hit_d;
  logic            dead_q;
  logic [NB-1:0]   hit_s;
  logic [CNTW-1:0] hit_cnt_s;
  logic            spawn_done_s;
  logic            clear_s;

  // Sums are widened to 11 bits so a box near the screen edge never wraps.
  function automatic logic in_window(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] cx, input logic [9:0] cy);
    logic [10:0] xe, ye, ce_x, ce_y;
    xe   = {1'b0, bx};
    ye   = {1'b0, by};
    ce_x = {1'b0, cx};
    ce_y = {1'b0, cy};
    return (xe + 11'(HIT_DX) > ce_x) && (xe < ce_x + 11'(HIT_DX)) &&
           (ye + 11'(HIT_DY) > ce_y) && (ye < ce_y + 11'(HIT_DY));
  endfunction

  // Per-slot collision flags and their population count.
  always_comb begin
    hit_cnt_s = '0;
    for (int i = 0; i < NB; i++) begin
      hit_s[i]  = v_q[i] & in_window(x_q[i], y_q[i], bossx, bossy);
      hit_cnt_s = hit_cnt_s + CNTW'(hit_s[i]);
    end
  end

  // Next-state logic: FSM, bullet movement/retire, spawn, cooldown and HP.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    x_d          = x_q;
    y_d          = y_q;
    cd_d         = (cd_q != '0) ? cd_q - CDW'(1) : '0;
    hp_d         = hp_q;
    hit_d        = 1'b0;
    spawn_done_s = 1'b0;
    clear_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear_s = 1'b1;
        hp_d    = 7'(BOSS_HP);
        if (boss) state_d = ST_FIGHT;
        else      state_d = ST_IDLE;
      end
      ST_FIGHT: begin
        if (!boss) begin
          state_d = ST_IDLE;
          clear_s = 1'b1;
          hp_d    = 7'(BOSS_HP);
        end else begin
          for (int i = 0; i < NB; i++) begin
            if (v_q[i] && hit_s[i])                       v_d[i] = 1'b0;
            else if (v_q[i] && (y_q[i] < 10'(SPEED + 8)))  v_d[i] = 1'b0;
            else if (v_q[i])                              y_d[i] = y_q[i] - 10'(SPEED);
            else                                          v_d[i] = 1'b0;
          end
          // Free slots are judged on the registered flags, so a slot retired now waits a tick.
          if (fire && (cd_q == '0)) begin
            for (int i = 0; i < NB; i++) begin
              if (!v_q[i] && !spawn_done_s) begin
                v_d[i]       = 1'b1;
                x_d[i]       = reimux;
                y_d[i]       = reimuy - 10'd16;
                spawn_done_s = 1'b1;
                cd_d         = CDW'(COOLDOWN);
              end else begin
                spawn_done_s = spawn_done_s;
              end
            end
          end else begin
            spawn_done_s = 1'b0;
          end
          hp_d  = (hp_q > 7'(hit_cnt_s)) ? hp_q - 7'(hit_cnt_s) : 7'd0;
          hit_d = (hit_cnt_s != '0);
          if (hp_d == 7'd0) begin
            state_d = ST_DEAD;
            clear_s = 1'b1;
          end else begin
            state_d = ST_FIGHT;
          end
        end
      end
      ST_DEAD: begin
        clear_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase
    if (clear_s) begin
      v_d = '0;
      for (int i = 0; i < NB; i++) begin
        x_d[i] = 10'd0;
        y_d[i] = 10'd0;
      end
    end else begin
      v_d = v_d;
    end
  end

  // State and output registers; gamestart behaves exactly like rst.
  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
      cd_q    <= '0;
      hp_q    <= 7'(BOSS_HP);
      hit_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cd_q    <= cd_d;
      hp_q    <= hp_d;
      hit_q   <= hit_d;
      dead_q  <= (state_d == ST_DEAD);
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_pack
    assign bullet_x[10*g +: 10] = x_q[g];
    assign bullet_y[10*g +: 10] = y_q[g];
  end

  assign bullet_v  = v_q;
  assign boss_hit  = hit_q;
  assign boss_hp   = hp_q;
  assign boss_dead = dead_q;

endmodule

// File: tb/tb_reimu_bullet.sv
// Bench for reimu_bullet: two instances (BOSS_HP 40 and 1) share stimulus and
// are compared every tick against a slot-array reference model plus directed checks.
module tb_reimu_bullet;

  logic        clk22 = 1'b0;
  logic        rst = 1'b1, gamestart = 1'b0, boss = 1'b0, fire = 1'b0;
  logic [9:0]  reimux = 10'd0, reimuy = 10'd0, bossx = 10'd900, bossy = 10'd50;
  logic [3:0]  v_a, v_b;
  logic [39:0] x_a, y_a, x_b, y_b;
  logic        hit_a, hit_b, dead_a, dead_b;
  logic [6:0]  hp_a, hp_b;

  always #5 clk22 = ~clk22;

  reimu_bullet u_dut (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .boss(boss), .fire(fire),
    .reimux(reimux), .reimuy(reimuy), .bossx(bossx), .bossy(bossy),
    .bullet_v(v_a), .bullet_x(x_a), .bullet_y(y_a),
    .boss_hit(hit_a), .boss_hp(hp_a), .boss_dead(dead_a)
  );

  reimu_bullet #(.BOSS_HP(1)) u_dut1 (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .boss(boss), .fire(fire),
    .reimux(reimux), .reimuy(reimuy), .bossx(bossx), .bossy(bossy),
    .bullet_v(v_b), .bullet_x(x_b), .bullet_y(y_b),
    .boss_hit(hit_b), .boss_hp(hp_b), .boss_dead(dead_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hp_init [2] = '{40, 1};
  // Model: mode 0 = title/idle, 1 = fighting, 2 = boss defeated.
  int mv [2][4];
  int mx [2][4];
  int my [2][4];
  int mhp [2];
  int mhit [2];
  int mmode [2];
  int mcd [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 4; i++) begin
      mv[k][i] = 0; mx[k][i] = 0; my[k][i] = 0;
    end
  endtask

  function automatic bit in_win(input int x, input int y);
    int bx = int'(bossx);
    int by = int'(bossy);
    return (x + 24 > bx) && (x < bx + 24) && (y + 28 > by) && (y < by + 28);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst || gamestart) begin
        model_clear(k);
        mhp[k] = hp_init[k]; mcd[k] = 0; mmode[k] = 0; mhit[k] = 0;
      end else if (mmode[k] == 1 && boss) begin
        int hits = 0;
        int was_live [4];
        bit spawned = 0;
        for (int i = 0; i < 4; i++) was_live[i] = mv[k][i];
        for (int i = 0; i < 4; i++) begin
          if (was_live[i] != 0) begin
            if (in_win(mx[k][i], my[k][i])) begin mv[k][i] = 0; hits++; end
            else if (my[k][i] < 20)         mv[k][i] = 0;
            else                            my[k][i] = my[k][i] - 12;
          end
        end
        if (fire && mcd[k] == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (was_live[i] == 0 && !spawned) begin
              mv[k][i] = 1; mx[k][i] = int'(reimux);
              my[k][i] = (int'(reimuy) - 16) & 1023;
              spawned = 1;
            end
          end
        end
        mcd[k]  = spawned ? 3 : (mcd[k] > 0 ? mcd[k] - 1 : 0);
        mhp[k]  = (mhp[k] > hits) ? mhp[k] - hits : 0;
        mhit[k] = (hits > 0) ? 1 : 0;
        if (mhp[k] == 0) begin mmode[k] = 2; model_clear(k); end
      end else begin
        mhit[k] = 0;
        mcd[k]  = mcd[k] > 0 ? mcd[k] - 1 : 0;
        model_clear(k);
        if (mmode[k] != 2) mhp[k] = hp_init[k];
        if (mmode[k] == 0 && boss)      mmode[k] = 1;
        else if (mmode[k] == 1)         mmode[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  dv;
      logic [39:0] dx, dy;
      int mvec = 0;
      dv = (k == 0) ? v_a : v_b;
      dx = (k == 0) ? x_a : x_b;
      dy = (k == 0) ? y_a : y_b;
      for (int i = 0; i < 4; i++) mvec |= (mv[k][i] << i);
      check_val($sformatf("u%0d_valid", k), int'(dv), mvec);
      check_val($sformatf("u%0d_hp", k), int'((k == 0) ? hp_a : hp_b), mhp[k]);
      check_val($sformatf("u%0d_hit", k), int'((k == 0) ? hit_a : hit_b), mhit[k]);
      check_val($sformatf("u%0d_dead", k), int'((k == 0) ? dead_a : dead_b),
                (mmode[k] == 2) ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
        if (mv[k][i] != 0) begin
          check_val($sformatf("u%0d_x%0d", k, i), int'(dx[10*i +: 10]), mx[k][i]);
          check_val($sformatf("u%0d_y%0d", k, i), int'(dy[10*i +: 10]), my[k][i]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk22);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; boss = 1'b0; gamestart = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Brings instance 0 to hp 25 with three live bullets.
  task automatic build_fight();
    do_reset();
    boss = 1'b1; reimux = 10'd300; reimuy = 10'd400; bossx = 10'd300; bossy = 10'd384;
    tick();
    fire = 1'b1;
    repeat (58) tick();
    check_val("pre_abort_hp", int'(hp_a), 25);
    bossx = 10'd900; bossy = 10'd50;
    repeat (12) tick();
    check_val("pre_abort_live", $countones(v_a), 3);
    fire = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    tick();
    rst = 1'b0;
    check_val("rst_v", int'(v_a), 0);
    check_val("rst_hp", int'(hp_a), 40);
    check_val("rst_hp1", int'(hp_b), 1);
    check_val("rst_dead", int'(dead_a), 0);
    check_val("rst_hit", int'(hit_a), 0);
    check_val("rst_xy", int'((x_a | y_a) != 40'd0), 0);

    // Single shot and upward movement
    boss = 1'b1; bossx = 10'd900; bossy = 10'd50;
    tick();
    reimux = 10'd200; reimuy = 10'd400; fire = 1'b1;
    tick();
    fire = 1'b0;
    check_val("shot_v", int'(v_a), 1);
    check_val("shot_x", int'(x_a[9:0]), 200);
    check_val("shot_y0", int'(y_a[9:0]), 384);
    tick(); check_val("shot_y1", int'(y_a[9:0]), 372);
    tick(); check_val("shot_y2", int'(y_a[9:0]), 360);
    tick(); check_val("shot_y3", int'(y_a[9:0]), 348);

    // Auto-fire with cooldown and a full pool
    do_reset();
    boss = 1'b1; tick();
    fire = 1'b1;
    repeat (12) tick();
    check_val("auto_three", int'(v_a), 7);
    tick();
    check_val("auto_four", int'(v_a), 15);
    repeat (8) tick();
    check_val("auto_full", int'(v_a), 15);
    fire = 1'b0;

    // Double hit in one tick; BOSS_HP=1 instance saturates and dies
    do_reset();
    boss = 1'b1; bossx = 10'd900; bossy = 10'd50; reimux = 10'd200; reimuy = 10'd400;
    tick();
    fire = 1'b1;
    repeat (5) tick();
    fire = 1'b0; bossx = 10'd200; bossy = 10'd360;
    tick();
    check_val("dbl_hit1", int'(hit_b), 1);
    check_val("dbl_hp1", int'(hp_b), 0);
    check_val("dbl_dead1", int'(dead_b), 1);
    check_val("dbl_v1", int'(v_b), 0);
    check_val("dbl_hp0", int'(hp_a), 38);
    check_val("dbl_hit0", int'(hit_a), 1);
    fire = 1'b1;
    repeat (4) tick();
    check_val("dead_nofire", int'(v_b), 0);
    check_val("dead_hold", int'(dead_b), 1);
    check_val("dead_nohit", int'(hit_b), 0);
    fire = 1'b0;

    // Top-edge retire
    do_reset();
    boss = 1'b1; bossx = 10'd900; bossy = 10'd50;
    tick();
    reimux = 10'd100; reimuy = 10'd35; fire = 1'b1;
    tick();
    fire = 1'b0;
    check_val("edge_y", int'(y_a[9:0]), 19);
    tick();
    check_val("edge_v", int'(v_a), 0);
    check_val("edge_hp", int'(hp_a), 40);
    check_val("edge_hit", int'(hit_a), 0);

    // Mid-fight abort via boss drop, then via gamestart
    build_fight();
    boss = 1'b0;
    tick();
    check_val("abort_v", int'(v_a), 0);
    check_val("abort_hp", int'(hp_a), 40);
    check_val("abort_dead", int'(dead_a), 0);
    build_fight();
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    check_val("gs_v", int'(v_a), 0);
    check_val("gs_hp", int'(hp_a), 40);
    check_val("gs_hp1", int'(hp_b), 1);
    check_val("gs_dead1", int'(dead_b), 0);

    // Randomized play against the reference model
    do_reset();
    boss = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      gamestart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) boss = ~boss;
      fire   = ($urandom_range(0, 3) != 0);
      reimux = 10'($urandom_range(40, 980));
      reimuy = 10'($urandom_range(0, 700));
      bossx  = 10'(int'(reimux) + $urandom_range(0, 60) - 30);
      bossy  = 10'($urandom_range(0, 450));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
